// File: rtl/multimode_ff_bank.sv
// Bank of run-time configurable SR/JK/D/T flip-flops
// with sticky SR-illegal flags and registered edge pulses.
module multimode_ff_bank #(
  parameter int         WIDTH       = 8,
  parameter logic [1:0] RESET_MODE  = 2'b01,
  parameter logic [1:0] SR11_POLICY = 2'b11,
  localparam int        SW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cfg_we,
  input  logic [SW-1:0]    cfg_sel,
  input  logic [1:0]       cfg_mode,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] err,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam logic [1:0] M_SR = 2'b00;
  localparam logic [1:0] M_JK = 2'b01;
  localparam logic [1:0] M_D  = 2'b10;
  localparam logic [1:0] M_T  = 2'b11;

  logic [1:0]       mode [WIDTH];
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] err_set;

  function automatic logic sr11(input logic cur);
    logic n;
    unique case (SR11_POLICY)
      2'b00:   n = cur;
      2'b01:   n = 1'b1;
      2'b10:   n = 1'b0;
      default: n = ~cur;
    endcase
    return n;
  endfunction

  // next state per channel, decoded by its mode
  always_comb begin
    q_nxt   = q;
    err_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (en) begin
        unique case (1'b1)
          (mode[i] == M_SR): begin
            unique case ({a[i], b[i]})
              2'b00: q_nxt[i] = q[i];
              2'b01: q_nxt[i] = 1'b0;
              2'b10: q_nxt[i] = 1'b1;
              default: begin
                q_nxt[i]   = sr11(q[i]);
                err_set[i] = 1'b1;
              end
            endcase
          end
          (mode[i] == M_JK): begin
            unique case ({a[i], b[i]})
              2'b00:   q_nxt[i] = q[i];
              2'b01:   q_nxt[i] = 1'b0;
              2'b10:   q_nxt[i] = 1'b1;
              default: q_nxt[i] = ~q[i];
            endcase
          end
          (mode[i] == M_D): q_nxt[i] = a[i];
          (mode[i] == M_T): q_nxt[i] = q[i] ^ a[i];
        endcase
      end
    end
  end

  // state, sticky flags (set beats clear) and edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      err  <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      q    <= q_nxt;
      err  <= (err & ~{WIDTH{err_clr}}) | err_set;
      rise <= q_nxt & ~q;
      fall <= ~q_nxt & q;
    end
  end

  // mode registers; out-of-range selects match no channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++)
        mode[i] <= RESET_MODE;
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (cfg_we && cfg_sel == SW'(i))
          mode[i] <= cfg_mode;
    end
  end

  assign qbar = ~q;

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Scoreboard bench: four policy variants of the bank
// plus a 5-wide bank for out-of-range mode selects.
module tb_multimode_ff_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] a, b;
  logic       cfg_we;
  logic [2:0] cfg_sel;
  logic [1:0] cfg_mode;
  logic       err_clr;
  logic [7:0] q_o [4];
  logic [7:0] qb_o [4];
  logic [7:0] err_o [4];
  logic [7:0] rise_o [4];
  logic [7:0] fall_o [4];

  logic       s_en, s_we;
  logic [2:0] s_sel;
  logic [4:0] s_q, s_qb, s_err, s_rise, s_fall;

  always #5 clk = ~clk;

  for (genvar p = 0; p < 4; p++) begin : g_pol
    multimode_ff_bank #(
      .WIDTH(8), .RESET_MODE(2'b01), .SR11_POLICY(2'(p))
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel),
      .cfg_mode(cfg_mode), .err_clr(err_clr),
      .q(q_o[p]), .qbar(qb_o[p]), .err(err_o[p]),
      .rise(rise_o[p]), .fall(fall_o[p])
    );
  end

  multimode_ff_bank #(.WIDTH(5)) u_small (
    .clk(clk), .rst_n(rst_n), .en(s_en),
    .a(a[4:0]), .b(b[4:0]),
    .cfg_we(s_we), .cfg_sel(s_sel),
    .cfg_mode(cfg_mode), .err_clr(err_clr),
    .q(s_q), .qbar(s_qb), .err(s_err),
    .rise(s_rise), .fall(s_fall)
  );

  typedef struct {
    string       tag;
    logic [31:0] q, err, rise, fall;
  } exp_t;

  exp_t       sbq [$];
  logic [7:0] mq [4];
  logic [7:0] merr;
  logic [1:0] mmode [8];
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic mnext(input logic [1:0] m,
                                 input logic s, input logic r,
                                 input logic c, input int pol);
    case (m)
      2'd0: begin
        if (s && r)
          return (pol == 0) ? c : (pol == 1) ? 1'b1 :
                 (pol == 2) ? 1'b0 : ~c;
        if (s) return 1'b1;
        if (r) return 1'b0;
        return c;
      end
      2'd1: begin
        if (s && r) return ~c;
        if (s) return 1'b1;
        if (r) return 1'b0;
        return c;
      end
      2'd2: return s;
      default: return s ? ~c : c;
    endcase
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 4; p++) mq[p] = '0;
    merr = '0;
    for (int i = 0; i < 8; i++) mmode[i] = 2'b01;
  endtask

  task automatic predict(input string tag);
    exp_t       e;
    logic [7:0] nq;
    logic [7:0] nerr;
    e.tag = tag;
    nerr = err_clr ? 8'h00 : merr;
    for (int i = 0; i < 8; i++)
      if (en && mmode[i] == 2'd0 && a[i] && b[i]) nerr[i] = 1'b1;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 8; i++)
        nq[i] = en ? mnext(mmode[i], a[i], b[i], mq[p][i], p)
                   : mq[p][i];
      e.q[p*8 +: 8]    = nq;
      e.rise[p*8 +: 8] = nq & ~mq[p];
      e.fall[p*8 +: 8] = ~nq & mq[p];
      e.err[p*8 +: 8]  = nerr;
      mq[p] = nq;
    end
    merr = nerr;
    if (cfg_we) mmode[cfg_sel] = cfg_mode;
    sbq.push_back(e);
  endtask

  task automatic step(input string tag);
    exp_t e;
    predict(tag);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({e.tag, "_q"},
        {q_o[3], q_o[2], q_o[1], q_o[0]}, e.q);
    chk({e.tag, "_qbar"},
        {qb_o[3], qb_o[2], qb_o[1], qb_o[0]}, ~e.q);
    chk({e.tag, "_err"},
        {err_o[3], err_o[2], err_o[1], err_o[0]}, e.err);
    chk({e.tag, "_rise"},
        {rise_o[3], rise_o[2], rise_o[1], rise_o[0]}, e.rise);
    chk({e.tag, "_fall"},
        {fall_o[3], fall_o[2], fall_o[1], fall_o[0]}, e.fall);
  endtask

  task automatic idle();
    en = 0; cfg_we = 0; err_clr = 0;
    a = '0; b = '0;
  endtask

  task automatic cfg(input logic [2:0] sel, input logic [1:0] m);
    idle();
    cfg_we = 1; cfg_sel = sel; cfg_mode = m;
    step("cfg");
    cfg_we = 0;
  endtask

  task automatic force_all(input logic v);
    idle();
    en = 1;
    for (int i = 0; i < 8; i++) begin
      case (mmode[i])
        2'd0, 2'd1: begin a[i] = v; b[i] = ~v; end
        2'd2:       a[i] = v;
        default:    a[i] = mq[0][i] ^ v;
      endcase
    end
    step("force");
  endtask

  logic [3:0] sr_i0, sr_i1;
  logic [3:0] tq, tr, tf;

  initial begin
    sr_i0 = 4'b1010;
    sr_i1 = 4'b0011;
    tq = 4'b1010; tr = 4'b1010; tf = 4'b0101;
    rst_n = 0;
    idle();
    cfg_sel = '0; cfg_mode = '0;
    s_en = 0; s_we = 0; s_sel = '0;
    model_reset();
    #2;
    chk("por_q", {24'h0, q_o[3]}, 32'h0);
    chk("por_qbar", {24'h0, qb_o[3]}, 32'hFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // error flag then A5 pattern, then asynchronous reset
    cfg(3'd5, 2'b00);
    en = 1; a = 8'h20; b = 8'h20;
    step("pre_err");
    a = 8'hA5; b = 8'h5A;
    step("load_a5");
    chk("a5_q", {24'h0, q_o[3]}, 32'hA5);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    for (int p = 0; p < 4; p++) begin
      chk("arst_q", {24'h0, q_o[p]}, 32'h0);
      chk("arst_qbar", {24'h0, qb_o[p]}, 32'hFF);
      chk("arst_err", {24'h0, err_o[p]}, 32'h0);
      chk("arst_rf", {16'h0, rise_o[p], fall_o[p]}, 32'h0);
    end
    #1;
    rst_n = 1;
    idle();
    en = 1; a = 8'hFF; b = 8'h00;
    step("jk_set");
    chk("jk_rise", {24'h0, rise_o[0]}, 32'hFF);
    step("jk_hold");
    chk("jk_rise_one", {24'h0, rise_o[0]}, 32'h0);

    // truth tables: ch0 SR, ch1 JK, ch2 D, ch3 T
    cfg(3'd0, 2'b00);
    cfg(3'd2, 2'b10);
    cfg(3'd3, 2'b11);
    cfg(3'd5, 2'b00);
    for (int init = 0; init < 2; init++) begin
      for (int c = 0; c < 4; c++) begin
        force_all(init[0]);
        idle();
        en = 1;
        a = c[1] ? 8'hFF : 8'h00;
        b = c[0] ? 8'hFF : 8'h00;
        step("tt");
        if (c == 3)
          for (int p = 0; p < 4; p++)
            chk("tt11", {28'h0, q_o[p][3:0]},
                {28'h0, (init == 0) ? 3'b111 : 3'b010,
                 (init == 0) ? sr_i0[p] : sr_i1[p]});
      end
    end

    // mode write at edge N uses the old mode
    cfg(3'd2, 2'b01);
    idle();
    en = 1; b = 8'hFF;
    step("clr_q");
    a = 8'hFF; b = 8'hFF;
    cfg_we = 1; cfg_sel = 3'd2; cfg_mode = 2'b10;
    step("mw_n");
    chk("mw_n_q2", {31'h0, q_o[3][2]}, 32'h1);
    cfg_we = 0;
    step("mw_n1");
    chk("mw_n1_q2", {31'h0, q_o[3][2]}, 32'h1);

    // sticky error and set-beats-clear
    idle();
    err_clr = 1;
    step("eclr0");
    idle();
    en = 1; a = 8'h20; b = 8'h20;
    step("eset");
    chk("eset5", {31'h0, err_o[3][5]}, 32'h1);
    idle();
    repeat (2) step("ehold");
    chk("ehold5", {31'h0, err_o[3][5]}, 32'h1);
    err_clr = 1; en = 1; a = 8'h20; b = 8'h20;
    step("ecoin");
    chk("ecoin5", {31'h0, err_o[3][5]}, 32'h1);
    idle();
    err_clr = 1;
    step("eclr");
    chk("eclr_all", {24'h0, err_o[3]}, 32'h0);

    // enable gating across all modes
    idle();
    a = 8'hFF; b = 8'hFF;
    repeat (5) step("gate");
    chk("gate_rf", {16'h0, rise_o[1], fall_o[1]}, 32'h0);

    // edge pulses on a T channel
    cfg(3'd0, 2'b11);
    if (mq[0][0]) begin
      idle(); en = 1; a = 8'h01;
      step("t_zero");
    end
    idle();
    en = 1; a = 8'h01;
    for (int k = 0; k < 4; k++) begin
      step("tpulse");
      chk("tp_q", {31'h0, q_o[3][0]}, {31'h0, tq[3-k]});
      chk("tp_rise", {31'h0, rise_o[3][0]}, {31'h0, tr[3-k]});
      chk("tp_fall", {31'h0, fall_o[3][0]}, {31'h0, tf[3-k]});
    end

    // out-of-range select on the 5-wide bank
    idle();
    s_we = 1; s_sel = 3'd5; cfg_mode = 2'b10;
    step("s_cfg");
    s_we = 0; s_en = 1;
    a = 8'hFF; b = 8'hFF;
    step("s_t1");
    chk("s_t1_q", {27'h0, s_q}, 32'h1F);
    step("s_t2");
    chk("s_t2_q", {27'h0, s_q}, 32'h0);
    s_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multimode_ff_bank.md
# multimode_ff_bank

Parametrised bank of WIDTH independent flip-flops. Each channel is configured at run time to behave as an SR, JK, D or T flip-flop. The block replaces single-purpose converted flip-flops in the sequential-primitives library. It adds per-channel mode registers, a configurable policy for the SR illegal input, a sticky illegal-input flag and registered edge-detect pulses. It sits between control logic driving the per-bit a/b inputs and downstream logic that consumes q, qbar and the edge pulses.

## Interface
- WIDTH, 8: number of channels, 1..32.
- RESET_MODE, 2'b01: mode loaded into every channel on reset. 00=SR, 01=JK, 10=D, 11=T.
- SR11_POLICY, 2'b11: SR-mode response to S=R=1. 00=hold, 01=set, 10=reset, 11=toggle.
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  update enable for all channels' q.
- a  in  WIDTH  per-channel first input: S, J, D or T by mode.
- b  in  WIDTH  per-channel second input: R or K; ignored in D and T modes.
- cfg_we  in  1  mode-register write strobe.
- cfg_sel  in  $clog2(WIDTH) (min 1)  channel index for the mode write.
- cfg_mode  in  2  mode value to write.
- err_clr  in  1  clears all sticky error flags.
- q  out  WIDTH  flip-flop state.
- qbar  out  WIDTH  always ~q, including during and after reset.
- err  out  WIDTH  sticky flag; set on SR-mode S=R=1 with en=1.
- rise  out  WIDTH  one-cycle pulse when q[i] went 0→1 on the previous edge.
- fall  out  WIDTH  one-cycle pulse when q[i] went 1→0 on the previous edge.

## Operation
- Per-channel next state, evaluated only when en=1. With en=0, q holds in every mode.
  - SR (00):
    - 00 hold
    - 01 q←0
    - 10 q←1
    - 11 per SR11_POLICY, and err[i]←1
  - JK (01):
    - 00 hold
    - 01 q←0
    - 10 q←1
    - 11 q←~q
  - D (10): q←a[i].
  - T (11): a[i]=1 toggles; a[i]=0 holds.
- Mode registers:
  - cfg_we=1 writes cfg_mode into mode[cfg_sel].
  - cfg_sel ≥ WIDTH: the write is ignored, with no side effects.
  - Writing a mode never alters q.
- Error flags:
  - err[i] sets only in SR mode with a[i]=b[i]=1 and en=1.
  - err_clr=1 clears all flags.
  - If a set and err_clr coincide on the same edge, the set wins for that channel.
- Edge pulses:
  - rise[i] = q_new & ~q_old, registered on the edge where q changes.
  - fall[i] = ~q_new & q_old, registered on the same edge.
  - Each pulse is high for exactly the cycle following the change edge.
  - Both pulses are 0 whenever q does not change, including with en=0.
- Reset (rst_n low, asynchronous):
  - q=0, qbar=all 1s
  - err=0, rise=0, fall=0
  - every mode[i]=RESET_MODE
  - Remains in effect while rst_n is low. Normal operation resumes on the first rising clk edge after rst_n deasserts.

## Timing
- q and qbar: latency 1. Inputs sampled at edge N are visible on q after edge N.
- rise and fall change on the same edge as q, so they are coincident with the new q value. No extra delay.
- err is visible after the edge that sampled the illegal input.
- Mode write at edge N:
  - The update of q at edge N still uses the old mode.
  - The new mode governs edge N+1 onward.
- Reset mid-operation: all outputs go to reset values immediately (asynchronously), regardless of clk. Pending cfg writes and err sets in that cycle are discarded.
- No combinational path from any input to any output.

## Test plan
- Reset/defaults:
  - Stimulus: assert rst_n=0 mid-run with q=8'hA5.
  - Required: q=8'h00, qbar=8'hFF, err=0, rise=fall=0 without a clk edge.
  - Required: after release, a=8'hFF, b=0, en=1 in JK mode gives q=8'hFF and rise=8'hFF for one cycle.
- Per-mode truth tables:
  - Stimulus: configure channels 0..3 as SR, JK, D, T and sweep a/b over all four combinations, each from q=0 and from q=1.
  - Required: JK 11 toggles; D follows a; T 1 toggles; SR 11 matches SR11_POLICY (run with all four parameter values).
- Mode write timing:
  - Stimulus: channel 2 in JK with q=0 and a=1, b=1, en=1 held; at edge N write cfg_mode=10 (D) to cfg_sel=2.
  - Required: q[2]=1 after edge N (JK toggle); after N+1, q[2]=1 (D follows a=1).
  - Required: cfg_sel=WIDTH changes no mode.
- Error flag:
  - Stimulus: SR channel 5 with a=b=1, en=1 for one cycle, then hold.
  - Required: err[5]=1 stays set.
  - Stimulus: err_clr together with a new S=R=1 on channel 5.
  - Required: err[5] stays 1. A clean err_clr clears it to 0.
- Enable gating:
  - Stimulus: en=0 with a=8'hFF, b=8'hFF in all modes for 5 cycles.
  - Required: q unchanged, rise=fall=0, err unchanged.
- Edge pulses:
  - Stimulus: T mode with a[0]=1, en=1 for 4 cycles from q=0.
  - Required: q[0]=1,0,1,0; rise[0]=1,0,1,0 and fall[0]=0,1,0,1 on the same cycles as q.
